// File: rtl/xbox_xlr_memcpy_pkg.sv
// Shared definitions for the XBOX line copy/fill accelerator: register map,
// command/status bit positions, FSM state type and the SRC/DST field layout.
package xbox_xlr_memcpy_pkg;

    localparam int REG_CMD      = 0;
    localparam int REG_SRC      = 1;
    localparam int REG_DST      = 2;
    localparam int REG_LEN      = 3;
    localparam int REG_STATUS   = 4;
    localparam int REG_CHECKSUM = 5;
    localparam int REG_CYCLES   = 6;
    localparam int REG_PATTERN  = 7;

    localparam int CMD_GO    = 0;
    localparam int CMD_ABORT = 1;
    localparam int CMD_FILL  = 2;

    localparam int ST_DONE         = 0;
    localparam int ST_BUSY         = 1;
    localparam int ST_ERROR        = 2;
    localparam int ST_ABORTED      = 3;
    localparam int ST_SOC_CONFLICT = 4;

    // Registers 4..6 are driven by the accelerator; everything else belongs to SW.
    localparam logic [31:0] OWNED_MASK = 32'h0000_0070;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_RD    = 3'd2,
        S_WR    = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic [7:0]  rsvd;
        logic [15:0] line;
        logic [7:0]  mem;
    } line_ref_t;

endpackage

// File: rtl/xbox_xlr_line_sum.sv
// Combinational 8x32 adder tree: mod-2^32 sum of the eight words of a line.
module xbox_xlr_line_sum
    import xbox_xlr_memcpy_pkg::*;
(
    input  logic [7:0][31:0] line,
    output logic [31:0]      sum
);
    logic [3:0][31:0] pair_sum;
    logic [1:0][31:0] quad_sum;

    always_comb begin
        for (int k = 0; k < 4; k++) pair_sum[k] = line[2*k] + line[2*k+1];
        for (int k = 0; k < 2; k++) quad_sum[k] = pair_sum[2*k] + pair_sum[2*k+1];
        sum = quad_sum[0] + quad_sum[1];
    end

endmodule

// File: rtl/xbox_xlr_memcpy.sv
// Host-register-controlled line copy/fill engine on the XBOX memory interface.
// Optional fill mode (CMD.fill, PATTERN register): define XBOX_XLR_MEMCPY_FILL_EN.
module xbox_xlr_memcpy
    import xbox_xlr_memcpy_pkg::*;
#(
    parameter int NUM_MEMS           = 4,
    parameter int LOG2_LINES_PER_MEM = 4
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    output logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0] xlr_mem_addr,
    output logic [NUM_MEMS-1:0][7:0][31:0]              xlr_mem_wdata,
    output logic [NUM_MEMS-1:0][31:0]                   xlr_mem_be,
    output logic [NUM_MEMS-1:0]                         xlr_mem_rd,
    output logic [NUM_MEMS-1:0]                         xlr_mem_wr,
    input  logic [NUM_MEMS-1:0][7:0][31:0]              xlr_mem_rdata,
    input  logic [31:0][31:0]                           host_regs,
    input  logic [31:0]                                 host_regs_valid_pulse,
    output logic [31:0][31:0]                           host_regs_data_out,
    output logic [31:0]                                 host_regs_valid_out,
    input  logic [18:0]                                 trig_soc_xmem_wr_addr,
    input  logic                                        trig_soc_xmem_wr
);
    localparam logic [31:0] LINES_PER_MEM = 32'd1 << LOG2_LINES_PER_MEM;
    localparam logic [31:0] MEM_COUNT     = 32'(NUM_MEMS);

    state_e          state_q, state_d;
    line_ref_t       src_ref, dst_ref;
    logic [7:0]      src_mem_q, dst_mem_q;
    logic [15:0]     src_line_q, dst_line_q;
    logic [16:0]     len_q, idx_q;
    logic [31:0]     checksum_q, cycles_q;
    logic            done_q, busy_q, error_q, aborted_q, conflict_q;
    logic            go, abort, range_err, last_line, fill_mode;
    logic [31:0]     src_end, dst_end, line_sum, status_word;
    logic [7:0][31:0] src_rdata, fill_line, wr_line;
    logic            unused_ok;

    assign src_ref = line_ref_t'(host_regs[REG_SRC]);
    assign dst_ref = line_ref_t'(host_regs[REG_DST]);
    assign go      = host_regs_valid_pulse[REG_CMD] & host_regs[REG_CMD][CMD_GO];
    assign abort   = host_regs_valid_pulse[REG_CMD] & host_regs[REG_CMD][CMD_ABORT];

    // Ranges are checked without wrap-around, so the sums are kept wide.
    assign src_end   = {16'd0, src_line_q} + {15'd0, len_q};
    assign dst_end   = {16'd0, dst_line_q} + {15'd0, len_q};
    assign range_err = ({24'd0, src_mem_q} >= MEM_COUNT) || ({24'd0, dst_mem_q} >= MEM_COUNT) ||
                       (src_end > LINES_PER_MEM) || (dst_end > LINES_PER_MEM);
    assign last_line = (idx_q == len_q - 17'd1);

`ifdef XBOX_XLR_MEMCPY_FILL_EN
    logic        fill_q;
    logic [31:0] pattern_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q    <= 1'b0;
            pattern_q <= '0;
        end else if (state_q == S_IDLE && go) begin
            fill_q    <= host_regs[REG_CMD][CMD_FILL];
            pattern_q <= host_regs[REG_PATTERN];
        end
    end

    assign fill_mode = fill_q;
    assign fill_line = {8{pattern_q}};
`else
    assign fill_mode = 1'b0;
    assign fill_line = '0;
`endif

    always_comb begin
        src_rdata = '0;
        for (int m = 0; m < NUM_MEMS; m++)
            if (src_mem_q == 8'(m)) src_rdata = xlr_mem_rdata[m];
    end

    assign wr_line = fill_mode ? fill_line : src_rdata;

    xbox_xlr_line_sum u_line_sum (
        .line (wr_line),
        .sum  (line_sum)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go) state_d = S_CHECK;
            S_CHECK: begin
                if (abort || range_err || len_q == 17'd0) state_d = S_DONE;
                else if (fill_mode)                        state_d = S_WR;
                else                                       state_d = S_RD;
            end
            S_RD:    state_d = abort ? S_DONE : S_WR;
            S_WR: begin
                if (abort || last_line) state_d = S_DONE;
                else if (fill_mode)     state_d = S_WR;
                else                    state_d = S_RD;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: asynchronous reset clears every state bit, so strobes drop the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            src_mem_q  <= '0;
            src_line_q <= '0;
            dst_mem_q  <= '0;
            dst_line_q <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            checksum_q <= '0;
            cycles_q   <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
            aborted_q  <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (go) begin
                    src_mem_q  <= src_ref.mem;
                    src_line_q <= src_ref.line;
                    dst_mem_q  <= dst_ref.mem;
                    dst_line_q <= dst_ref.line;
                    len_q      <= host_regs[REG_LEN][16:0];
                    idx_q      <= '0;
                    checksum_q <= '0;
                    cycles_q   <= '0;
                    done_q     <= 1'b0;
                    error_q    <= 1'b0;
                    aborted_q  <= 1'b0;
                    conflict_q <= 1'b0;
                    busy_q     <= 1'b1;
                end
                S_CHECK: begin
                    if (abort)          aborted_q <= 1'b1;
                    else if (range_err) error_q   <= 1'b1;
                end
                S_RD: if (abort) aborted_q <= 1'b1;
                S_WR: begin
                    checksum_q <= checksum_q + line_sum;
                    idx_q      <= idx_q + 17'd1;
                    if (abort) aborted_q <= 1'b1;
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
            if ((state_q == S_RD || state_q == S_WR) && cycles_q != '1)
                cycles_q <= cycles_q + 32'd1;
            if (busy_q && trig_soc_xmem_wr)
                conflict_q <= 1'b1;
        end
    end

    // NOTE: every combinational output gets a default first, so no latches are inferred.
    always_comb begin
        xlr_mem_addr  = '0;
        xlr_mem_wdata = '0;
        xlr_mem_be    = '0;
        xlr_mem_rd    = '0;
        xlr_mem_wr    = '0;
        for (int m = 0; m < NUM_MEMS; m++) begin
            if (state_q == S_RD && src_mem_q == 8'(m)) begin
                xlr_mem_rd[m]   = 1'b1;
                xlr_mem_addr[m] = LOG2_LINES_PER_MEM'({1'b0, src_line_q} + idx_q);
            end
            if (state_q == S_WR && dst_mem_q == 8'(m)) begin
                xlr_mem_wr[m]    = 1'b1;
                xlr_mem_addr[m]  = LOG2_LINES_PER_MEM'({1'b0, dst_line_q} + idx_q);
                xlr_mem_be[m]    = '1;
                xlr_mem_wdata[m] = wr_line;
            end
        end
    end

    always_comb begin
        status_word                  = '0;
        status_word[ST_DONE]         = done_q;
        status_word[ST_BUSY]         = busy_q;
        status_word[ST_ERROR]        = error_q;
        status_word[ST_ABORTED]      = aborted_q;
        status_word[ST_SOC_CONFLICT] = conflict_q;
        host_regs_data_out               = '0;
        host_regs_data_out[REG_STATUS]   = status_word;
        host_regs_data_out[REG_CHECKSUM] = checksum_q;
        host_regs_data_out[REG_CYCLES]   = cycles_q;
    end

    assign host_regs_valid_out = rst_n ? OWNED_MASK : '0;

    // Fields SW may write but this block never looks at.
    assign unused_ok = ^{trig_soc_xmem_wr_addr, host_regs, host_regs_valid_pulse, src_ref, dst_ref};

endmodule

// File: tb/tb_xbox_xlr_memcpy.sv
// Scoreboard bench for xbox_xlr_memcpy: a line-level reference model predicts writes
// and final register values; a monitor compares every write strobe against the queue.
module tb_xbox_xlr_memcpy;
    import xbox_xlr_memcpy_pkg::*;

    localparam int NM    = 4;
    localparam int LW    = 4;
    localparam int LINES = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NM-1:0][LW-1:0]     xlr_mem_addr;
    logic [NM-1:0][7:0][31:0]  xlr_mem_wdata;
    logic [NM-1:0][31:0]       xlr_mem_be;
    logic [NM-1:0]             xlr_mem_rd, xlr_mem_wr;
    logic [NM-1:0][7:0][31:0]  xlr_mem_rdata = '0;
    logic [31:0][31:0]         host_regs = '0;
    logic [31:0]               host_regs_valid_pulse = '0;
    logic [31:0][31:0]         host_regs_data_out;
    logic [31:0]               host_regs_valid_out;
    logic [18:0]               trig_soc_xmem_wr_addr = '0;
    logic                      trig_soc_xmem_wr = 1'b0;

    xbox_xlr_memcpy #(.NUM_MEMS(NM), .LOG2_LINES_PER_MEM(LW)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .xlr_mem_addr          (xlr_mem_addr),
        .xlr_mem_wdata         (xlr_mem_wdata),
        .xlr_mem_be            (xlr_mem_be),
        .xlr_mem_rd            (xlr_mem_rd),
        .xlr_mem_wr            (xlr_mem_wr),
        .xlr_mem_rdata         (xlr_mem_rdata),
        .host_regs             (host_regs),
        .host_regs_valid_pulse (host_regs_valid_pulse),
        .host_regs_data_out    (host_regs_data_out),
        .host_regs_valid_out   (host_regs_valid_out),
        .trig_soc_xmem_wr_addr (trig_soc_xmem_wr_addr),
        .trig_soc_xmem_wr      (trig_soc_xmem_wr)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int           mem;
        int           addr;
        logic [255:0] data;
    } wr_t;

    typedef struct {
        int          sm, sl, dm, dl, len;
        bit          fill;
        logic [31:0] pat;
        bit          go_abort;
        int          abort_cyc, busy_go_cyc, soc_cyc, rst_cyc;
    } cmd_t;

    wr_t          exp_q[$];
    logic [255:0] mem_arr [NM][LINES];
    logic [255:0] ref_mem [NM][LINES];

    logic         load_en = 1'b0;
    int           load_m = 0, load_a = 0;
    logic [255:0] load_d = '0;

    // Memory instances: read data appears the cycle after rd.
    always @(posedge clk) begin
        if (load_en) mem_arr[load_m][load_a] <= load_d;
        for (int m = 0; m < NM; m++) begin
            if (xlr_mem_rd[m]) xlr_mem_rdata[m] <= mem_arr[m][xlr_mem_addr[m]];
            if (xlr_mem_wr[m]) mem_arr[m][xlr_mem_addr[m]] <= xlr_mem_wdata[m];
        end
    end

    // Monitor: every write strobe is matched against the head of the expected queue.
    initial begin
        wr_t e;
        int  nstr;
        forever begin
            @(negedge clk);
            nstr = $countones(xlr_mem_rd) + $countones(xlr_mem_wr);
            if (nstr != 0) begin
                check("single_strobe", nstr, 1);
                for (int m = 0; m < NM; m++) begin
                    if (xlr_mem_wr[m]) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_write", xlr_mem_wr[m], 1'b0);
                        end else begin
                            e = exp_q.pop_front();
                            check("wr_mem", m, e.mem);
                            check("wr_addr", xlr_mem_addr[m], e.addr);
                            check("wr_data", xlr_mem_wdata[m], e.data);
                            check("wr_be", xlr_mem_be[m], 32'hFFFF_FFFF);
                        end
                    end else if (!xlr_mem_rd[m]) begin
                        check("idle_lane_zero",
                              (|xlr_mem_addr[m]) | (|xlr_mem_wdata[m]) | (|xlr_mem_be[m]), 1'b0);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    function automatic logic [31:0] words_sum(input logic [255:0] d);
        logic [31:0] s = '0;
        for (int w = 0; w < 8; w++) s += d[32*w +: 32];
        return s;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] d;
        for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom;
        return d;
    endfunction

    function automatic cmd_t new_cmd(input int sm, sl, dm, dl, len);
        cmd_t c;
        c.sm = sm; c.sl = sl; c.dm = dm; c.dl = dl; c.len = len;
        c.fill = 1'b0; c.pat = '0; c.go_abort = 1'b0;
        c.abort_cyc = 0; c.busy_go_cyc = 0; c.soc_cyc = 0; c.rst_cyc = 0;
        return c;
    endfunction

    task automatic load(input int m, input int a, input logic [255:0] d);
        load_en = 1'b1; load_m = m; load_a = a; load_d = d;
        ref_mem[m][a] = d;
        @(posedge clk);
        #1 load_en = 1'b0;
    endtask

    task automatic run_cmd(input cmd_t c);
        bit          err, do_fill, aborted, conflict, seen;
        int          work, nlines, done_cyc, exp_cycles;
        logic [31:0] exp_sum, exp_status;
        logic [255:0] d;

        // Reference model: outcome of the command in terms of lines, cycles and flags.
        err = (c.sm >= NM) || (c.dm >= NM) || (c.sl + c.len > LINES) || (c.dl + c.len > LINES);
`ifdef XBOX_XLR_MEMCPY_FILL_EN
        do_fill = c.fill;
`else
        do_fill = 1'b0;
`endif
        work    = do_fill ? c.len : 2 * c.len;
        aborted = 1'b0;
        if (c.abort_cyc == 1) begin
            nlines = 0; done_cyc = 3; exp_cycles = 0; aborted = 1'b1; err = 1'b0;
        end else if (err || c.len == 0) begin
            nlines = 0; done_cyc = 3; exp_cycles = 0;
        end else if (c.abort_cyc >= 2 && c.abort_cyc <= work + 1) begin
            nlines     = do_fill ? c.abort_cyc - 1 : (c.abort_cyc - 1) / 2;
            done_cyc   = c.abort_cyc + 2;
            exp_cycles = c.abort_cyc - 1;
            aborted    = 1'b1;
        end else begin
            nlines = c.len; done_cyc = work + 3; exp_cycles = work;
        end
        if (c.rst_cyc != 0) nlines = (c.rst_cyc - 1) / 2;
        conflict   = (c.soc_cyc >= 1) && (c.soc_cyc <= done_cyc - 1);
        exp_status = 32'h1 | (err ? 32'h4 : 32'h0) | (aborted ? 32'h8 : 32'h0) | (conflict ? 32'h10 : 32'h0);

        exp_sum = '0;
        for (int j = 0; j < nlines; j++) begin
            d = do_fill ? {8{c.pat}} : ref_mem[c.sm][c.sl + j];
            ref_mem[c.dm][c.dl + j] = d;
            exp_q.push_back('{mem: c.dm, addr: c.dl + j, data: d});
            exp_sum += words_sum(d);
        end

        @(negedge clk);
        host_regs[REG_SRC]     = {8'd0, 16'(c.sl), 8'(c.sm)};
        host_regs[REG_DST]     = {8'd0, 16'(c.dl), 8'(c.dm)};
        host_regs[REG_LEN]     = 32'(c.len);
        host_regs[REG_PATTERN] = c.pat;
        host_regs[REG_CMD]     = {29'd0, c.fill, c.go_abort, 1'b1};
        host_regs_valid_pulse  = 32'h1;
        @(posedge clk);
        #1 host_regs_valid_pulse = '0;

        seen = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            trig_soc_xmem_wr = (cyc == c.soc_cyc);
            host_regs_valid_pulse = '0;
            if (cyc == c.abort_cyc) begin
                host_regs[REG_CMD]    = 32'h3;
                host_regs_valid_pulse = 32'h1;
            end else if (cyc == c.busy_go_cyc) begin
                host_regs[REG_SRC]    = {8'd0, 16'd9, 8'd3};
                host_regs[REG_CMD]    = 32'h1;
                host_regs_valid_pulse = 32'h1;
            end
            if (cyc == 1) check("busy_in_cycle1", host_regs_data_out[REG_STATUS], 32'h2);
            if (host_regs_data_out[REG_STATUS][0]) begin
                seen = 1'b1;
                check("done_cycle", cyc, done_cyc);
                check("status", host_regs_data_out[REG_STATUS], exp_status);
                check("checksum", host_regs_data_out[REG_CHECKSUM], exp_sum);
                check("cycles", host_regs_data_out[REG_CYCLES], exp_cycles);
                break;
            end
            if (cyc == c.rst_cyc) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_rd", xlr_mem_rd, '0);
                check("rst_wr", xlr_mem_wr, '0);
                check("rst_mem_outs", (|xlr_mem_addr) | (|xlr_mem_wdata) | (|xlr_mem_be), 1'b0);
                check("rst_data_out", |host_regs_data_out, 1'b0);
                check("rst_valid_out", host_regs_valid_out, '0);
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
        end
        host_regs_valid_pulse = '0;
        trig_soc_xmem_wr      = 1'b0;
        if (c.rst_cyc == 0) check("done_seen", seen, 1'b1);
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        cmd_t c;
        int   mx;

        repeat (3) @(negedge clk);
        check("reset_valid_out", host_regs_valid_out, '0);
        check("reset_data_out", |host_regs_data_out, 1'b0);
        check("reset_strobes", {xlr_mem_rd, xlr_mem_wr}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("valid_out_owned", host_regs_valid_out, 32'h70);
        check("data_out_idle", |host_regs_data_out, 1'b0);

        for (int m = 0; m < NM; m++)
            for (int a = 0; a < LINES; a++) load(m, a, rand_line());

        // Basic copy: mem1 lines 0..3 -> mem2 lines 4..7.
        for (int k = 0; k < 4; k++) load(1, k, {8{32'(k + 1)}});
        run_cmd(new_cmd(1, 0, 2, 4, 4));
        for (int k = 0; k < 4; k++) check("copy_dst_line", mem_arr[2][4 + k], {8{32'(k + 1)}});
        check("copy_checksum_80", host_regs_data_out[REG_CHECKSUM], 32'd80);
        check("copy_cycles_8", host_regs_data_out[REG_CYCLES], 32'd8);

        // Range errors, exact-fit boundary and zero length.
        run_cmd(new_cmd(4, 0, 2, 0, 2));
        run_cmd(new_cmd(1, 0, 2, 14, 3));
        run_cmd(new_cmd(1, 0, 2, 12, 4));
        run_cmd(new_cmd(1, 0, 2, 0, 0));

        // Abort in cycle 6 together with go; a go while busy is ignored.
        c = new_cmd(1, 0, 2, 0, 10);
        c.abort_cyc = 6; c.busy_go_cyc = 4;
        run_cmd(c);
        check("abort_status_9", host_regs_data_out[REG_STATUS], 32'h9);

        // Fill with a fixed pattern.
        c = new_cmd(0, 0, 3, 2, 2);
        c.fill = 1'b1; c.pat = 32'hA5A5_A5A5;
        run_cmd(c);
`ifdef XBOX_XLR_MEMCPY_FILL_EN
        check("fill_line0", mem_arr[3][2], {8{32'hA5A5_A5A5}});
        check("fill_line1", mem_arr[3][3], {8{32'hA5A5_A5A5}});
`endif

        // SOC write during copy, then a reset in the middle of a copy.
        c = new_cmd(2, 3, 1, 5, 3);
        c.soc_cyc = 3;
        run_cmd(c);
        c = new_cmd(0, 0, 1, 8, 4);
        c.rst_cyc = 6;
        run_cmd(c);

        // Overlapping forward copy in one memory.
        run_cmd(new_cmd(3, 2, 3, 4, 6));

        for (int n = 0; n < 40; n++) begin
            c = new_cmd($urandom_range(0, NM - 1), $urandom_range(0, LINES - 1),
                        $urandom_range(0, NM - 1), $urandom_range(0, LINES - 1), 0);
            if ($urandom_range(0, 9) == 0) c.sm = NM + $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) c.dm = NM + $urandom_range(0, 3);
            mx = LINES - ((c.sl > c.dl) ? c.sl : c.dl);
            if ($urandom_range(0, 7) == 0) c.len = $urandom_range(0, LINES + 1);
            else                           c.len = $urandom_range(0, (mx > 6) ? 6 : mx);
            c.fill     = 1'($urandom_range(0, 1));
            c.pat      = $urandom;
            c.go_abort = 1'($urandom_range(0, 1));
            if (c.len > 0 && $urandom_range(0, 4) == 0) c.abort_cyc = $urandom_range(1, 2 * c.len + 1);
            if ($urandom_range(0, 3) == 0) c.soc_cyc = $urandom_range(1, 2 * c.len + 4);
            run_cmd(c);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
